dds_core: RTL and testbench

- Direct digital synthesis sine generator.
- A 9-bit phase accumulator advances by Fword every clock. Pword is added as a phase offset.
- The resulting 9-bit address drives a quarter-wave-symmetric 512-point sine lookup. The lookup produces 12-bit offset-binary samples for an external DAC.
- Sits between the control registers (Fword/Pword) and the DAC data bus.

---
 rtl/dds_core_if.sv | 13 +
 rtl/dds_core.sv | 86 ++++++++
 tb/tb_dds_core.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dds_core_if.sv
// dds_core_if: control words in, DAC sample out, between register block and DDS core.
// Latency: none (wires only).
// Backpressure: none; words are sampled every clock and the sample is always valid.
interface dds_core_if;
  logic [7:0]  Fword;    // phase increment per clock
  logic [8:0]  Pword;    // phase offset, 512 counts = one full turn
  logic [11:0] DA_Data;  // offset-binary sine sample

  // Control side: drives the tuning words and receives the DAC sample.
  modport master (output Fword, output Pword, input DA_Data);
  // DDS side: consumes the tuning words and produces the DAC sample.
  modport slave  (input Fword, input Pword, output DA_Data);
endinterface

// File: rtl/dds_core.sv
// dds_core: 9-bit phase accumulator plus quarter-wave 512-point sine LUT, 12-bit offset-binary out.
// Latency: Pword reaches DA_Data 2 edges later; Fword changes the increment applied at the next edge.
// Backpressure: none; runs every clock and the DAC consumes every sample.
module dds_core (
  input  logic      clk,
  input  logic      reset,
  dds_core_if.slave dac
);

  logic [8:0]  acc_q,  acc_d;
  logic [8:0]  addr_q, addr_d;
  logic [11:0] da_q,   da_d;
  logic [6:0]  qidx;
  logic [10:0] qval;

  // Advance the phase and form the lookup address from the pre-update phase; carries drop for mod-512 wrap.
  always_comb begin
    acc_d  = acc_q + {1'b0, dac.Fword};
    addr_d = acc_q + dac.Pword;
  end

  // Quadrants 1 and 3 walk the quarter table backwards; 127-i is simply ~i.
  always_comb begin
    qidx = addr_q[7] ? ~addr_q[6:0] : addr_q[6:0];
  end

  // Quarter table: T[i] = round(2047*sin(2*pi*(i+0.5)/512)); half-step offset keeps both ends off the axes.
  always_comb begin
    qval = 11'd0;
    case (qidx)
      7'd0:   qval = 11'd13;   7'd1:   qval = 11'd38;   7'd2:   qval = 11'd63;   7'd3:   qval = 11'd88;
      7'd4:   qval = 11'd113;  7'd5:   qval = 11'd138;  7'd6:   qval = 11'd163;  7'd7:   qval = 11'd188;
      7'd8:   qval = 11'd213;  7'd9:   qval = 11'd238;  7'd10:  qval = 11'd263;  7'd11:  qval = 11'd288;
      7'd12:  qval = 11'd313;  7'd13:  qval = 11'd338;  7'd14:  qval = 11'd362;  7'd15:  qval = 11'd387;
      7'd16:  qval = 11'd412;  7'd17:  qval = 11'd436;  7'd18:  qval = 11'd461;  7'd19:  qval = 11'd485;
      7'd20:  qval = 11'd510;  7'd21:  qval = 11'd534;  7'd22:  qval = 11'd558;  7'd23:  qval = 11'd582;
      7'd24:  qval = 11'd606;  7'd25:  qval = 11'd630;  7'd26:  qval = 11'd654;  7'd27:  qval = 11'd678;
      7'd28:  qval = 11'd701;  7'd29:  qval = 11'd725;  7'd30:  qval = 11'd748;  7'd31:  qval = 11'd772;
      7'd32:  qval = 11'd795;  7'd33:  qval = 11'd818;  7'd34:  qval = 11'd841;  7'd35:  qval = 11'd864;
      7'd36:  qval = 11'd887;  7'd37:  qval = 11'd909;  7'd38:  qval = 11'd932;  7'd39:  qval = 11'd954;
      7'd40:  qval = 11'd976;  7'd41:  qval = 11'd998;  7'd42:  qval = 11'd1020; 7'd43:  qval = 11'd1042;
      7'd44:  qval = 11'd1063; 7'd45:  qval = 11'd1085; 7'd46:  qval = 11'd1106; 7'd47:  qval = 11'd1127;
      7'd48:  qval = 11'd1148; 7'd49:  qval = 11'd1168; 7'd50:  qval = 11'd1189; 7'd51:  qval = 11'd1209;
      7'd52:  qval = 11'd1229; 7'd53:  qval = 11'd1249; 7'd54:  qval = 11'd1269; 7'd55:  qval = 11'd1289;
      7'd56:  qval = 11'd1308; 7'd57:  qval = 11'd1328; 7'd58:  qval = 11'd1347; 7'd59:  qval = 11'd1365;
      7'd60:  qval = 11'd1384; 7'd61:  qval = 11'd1402; 7'd62:  qval = 11'd1421; 7'd63:  qval = 11'd1439;
      7'd64:  qval = 11'd1456; 7'd65:  qval = 11'd1474; 7'd66:  qval = 11'd1491; 7'd67:  qval = 11'd1508;
      7'd68:  qval = 11'd1525; 7'd69:  qval = 11'd1542; 7'd70:  qval = 11'd1558; 7'd71:  qval = 11'd1574;
      7'd72:  qval = 11'd1590; 7'd73:  qval = 11'd1606; 7'd74:  qval = 11'd1621; 7'd75:  qval = 11'd1637;
      7'd76:  qval = 11'd1652; 7'd77:  qval = 11'd1666; 7'd78:  qval = 11'd1681; 7'd79:  qval = 11'd1695;
      7'd80:  qval = 11'd1709; 7'd81:  qval = 11'd1723; 7'd82:  qval = 11'd1736; 7'd83:  qval = 11'd1749;
      7'd84:  qval = 11'd1762; 7'd85:  qval = 11'd1775; 7'd86:  qval = 11'd1787; 7'd87:  qval = 11'd1799;
      7'd88:  qval = 11'd1811; 7'd89:  qval = 11'd1823; 7'd90:  qval = 11'd1834; 7'd91:  qval = 11'd1845;
      7'd92:  qval = 11'd1856; 7'd93:  qval = 11'd1866; 7'd94:  qval = 11'd1876; 7'd95:  qval = 11'd1886;
      7'd96:  qval = 11'd1896; 7'd97:  qval = 11'd1905; 7'd98:  qval = 11'd1914; 7'd99:  qval = 11'd1923;
      7'd100: qval = 11'd1932; 7'd101: qval = 11'd1940; 7'd102: qval = 11'd1948; 7'd103: qval = 11'd1955;
      7'd104: qval = 11'd1962; 7'd105: qval = 11'd1969; 7'd106: qval = 11'd1976; 7'd107: qval = 11'd1983;
      7'd108: qval = 11'd1989; 7'd109: qval = 11'd1994; 7'd110: qval = 11'd2000; 7'd111: qval = 11'd2005;
      7'd112: qval = 11'd2010; 7'd113: qval = 11'd2015; 7'd114: qval = 11'd2019; 7'd115: qval = 11'd2023;
      7'd116: qval = 11'd2027; 7'd117: qval = 11'd2030; 7'd118: qval = 11'd2033; 7'd119: qval = 11'd2036;
      7'd120: qval = 11'd2038; 7'd121: qval = 11'd2040; 7'd122: qval = 11'd2042; 7'd123: qval = 11'd2044;
      7'd124: qval = 11'd2045; 7'd125: qval = 11'd2046; 7'd126: qval = 11'd2047; 7'd127: qval = 11'd2047;
    endcase
  end

  // Lower half sits above midscale; upper half mirrors it as 2047-T, so LUT(a)+LUT(a+256)=4095 exactly.
  always_comb begin
    da_d = addr_q[8] ? (12'd2047 - {1'b0, qval}) : (12'd2048 + {1'b0, qval});
  end

  // State update; reset parks the phase at zero and the DAC at midscale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= 9'd0;
      addr_q <= 9'd0;
      da_q   <= 12'h800;
    end else begin
      acc_q  <= acc_d;
      addr_q <= addr_d;
      da_q   <= da_d;
    end
  end

  assign dac.DA_Data = da_q;

endmodule

// File: tb/tb_dds_core.sv
// tb_dds_core: directed vectors against dds_core with hand-worked sample values and a sine model.
// Latency: samples are taken 1 time unit after each rising edge.
// Backpressure: none; stimulus changes between edges.
module tb_dds_core;

  logic clk;
  logic reset;
  dds_core_if bus ();

  dds_core dut (
    .clk   (clk),
    .reset (reset),
    .dac   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int qt [128];
  int s  [2560];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference LUT built from the sine definition.
  function automatic int lut_ref(input int a);
    int q;
    int i;
    q = (a >> 7) & 3;
    i = a & 127;
    if (q == 1 || q == 3) i = 127 - i;
    return (q < 2) ? (2048 + qt[i]) : (2047 - qt[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges with new control words; next edge is edge 1.
  task automatic restart(input int f, input int p);
    reset     = 1'b1;
    bus.Fword = f[7:0];
    bus.Pword = p[8:0];
    #2;
    reset     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mx;
    int mn;
    for (int i = 0; i < 128; i++)
      qt[i] = $rtoi(2047.0 * $sin(2.0 * 3.14159265358979 * (real'(i) + 0.5) / 512.0) + 0.5);

    // Reset before any clock edge, then held across edges.
    reset     = 1'b1;
    bus.Fword = 8'd1;
    bus.Pword = 9'd0;
    #3;
    check("rst_async", int'(bus.DA_Data), 2048);
    repeat (3) tick();
    check("rst_hold", int'(bus.DA_Data), 2048);

    // Fword=1, Pword=0 sweep over 5 full periods.
    reset = 1'b0;
    tick();
    check("f1_edge1", int'(bus.DA_Data), 2061);
    tick();
    check("f1_edge2", int'(bus.DA_Data), 2061);
    s[0] = int'(bus.DA_Data);
    tick();
    check("f1_edge3", int'(bus.DA_Data), 2086);
    s[1] = int'(bus.DA_Data);
    for (int n = 4; n <= 2561; n++) begin
      tick();
      s[n-2] = int'(bus.DA_Data);
      check("f1_sweep", s[n-2], lut_ref((n - 2) % 512));
      if (n == 130) check("f1_peak_a128", s[n-2], 4095);
      if (n == 386) check("f1_trough_a384", s[n-2], 0);
    end
    mx = -1;
    mn = 99999;
    for (int j = 0; j < 2560; j++) begin
      if (s[j] > mx) mx = s[j];
      if (s[j] < mn) mn = s[j];
    end
    check("f1_max", mx, 4095);
    check("f1_min", mn, 0);
    for (int j = 0; j < 256; j++)
      check("f1_symmetry", s[j] + s[j+256], 4095);

    // Reset mid-run must act at once, then restart with Fword=2, Pword=255.
    reset = 1'b1;
    #1;
    check("rst_mid_async", int'(bus.DA_Data), 2048);
    bus.Fword = 8'd2;
    bus.Pword = 9'd255;
    tick();
    check("rst_mid_hold", int'(bus.DA_Data), 2048);
    reset = 1'b0;
    tick();
    check("f2_edge1", int'(bus.DA_Data), 2061);
    tick();
    check("f2_edge2", int'(bus.DA_Data), 2061);
    tick();
    check("f2_edge3", int'(bus.DA_Data), 2009);
    for (int n = 4; n <= 1281; n++) begin
      tick();
      check("f2_sweep", int'(bus.DA_Data), lut_ref((2 * (n - 2) + 255) % 512));
    end

    // Pword step 0 -> 128 with Fword=1: quarter-period jump two edges later.
    restart(1, 0);
    repeat (50) tick();
    check("pstep_pre", int'(bus.DA_Data), 3196);
    bus.Pword = 9'd128;
    tick();
    check("pstep_edge1", int'(bus.DA_Data), 3216);
    tick();
    check("pstep_edge2", int'(bus.DA_Data), 3714);
    tick();
    check("pstep_edge3", int'(bus.DA_Data), 3700);

    // Fword=0 freezes the phase; output settles at LUT(64).
    restart(0, 64);
    tick();
    check("f0_edge1", int'(bus.DA_Data), 2061);
    for (int n = 2; n <= 7; n++) begin
      tick();
      check("f0_const", int'(bus.DA_Data), 3504);
    end

    // Fword=255: address sequence 0,255,510,253,... through many wraps.
    restart(255, 0);
    tick();
    check("f255_edge1", int'(bus.DA_Data), 2061);
    for (int n = 2; n <= 601; n++) begin
      tick();
      check("f255_sweep", int'(bus.DA_Data), lut_ref(((n - 2) * 255) % 512));
      if (n == 3) check("f255_a255", int'(bus.DA_Data), 2061);
      if (n == 4) check("f255_a510", int'(bus.DA_Data), 2009);
      if (n == 5) check("f255_a253", int'(bus.DA_Data), 2111);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
